// File: rtl/stream_align_pkg.sv
// stream_align_pkg: aligner FSM state encoding and default frame geometry
package stream_align_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam int H_PIXELS = 640;
  localparam int V_LINES  = 480;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: one-stage valid/ready output register; ports s_* (upstream side), m_* (downstream side), s_ready = slot free
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  assign s_ready = !m_valid || m_ready;
  always_ff @(posedge clk)
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
endmodule

// File: rtl/stream_aligner_sync.sv
// stream_aligner_sync: joins camera and reference AXI4-Streams beat-for-beat from a common SOF; ports: enable, s_cam_* / s_ref_* inputs, m_* joined {cam,ref} output, aligned, resync_count
module stream_aligner_sync
  import stream_align_pkg::*;
#(
  parameter int CAM_W        = 16,
  parameter int REF_W        = 16,
  parameter int FRAME_PIXELS = H_PIXELS * V_LINES,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [CAM_W-1:0]       s_cam_tdata,
  input  logic                   s_cam_tvalid,
  input  logic                   s_cam_tuser,
  input  logic                   s_cam_tlast,
  output logic                   s_cam_tready,
  input  logic [REF_W-1:0]       s_ref_tdata,
  input  logic                   s_ref_tvalid,
  input  logic                   s_ref_tuser,
  output logic                   s_ref_tready,
  output logic [CAM_W+REF_W-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tuser,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   aligned,
  output logic [CNT_W-1:0]       resync_count
);
  localparam int PC_W = $clog2(FRAME_PIXELS + 1);
  logic [1:0] state, state_n;
  logic [PC_W-1:0] pix_cnt;
  logic slot_free, cam_sof, ref_sof, both_v, join_ok, mismatch, eof;
  assign cam_sof  = s_cam_tvalid && s_cam_tuser;
  assign ref_sof  = s_ref_tvalid && s_ref_tuser;
  assign both_v   = s_cam_tvalid && s_ref_tvalid;
  assign join_ok  = state == RUN && both_v && slot_free && s_cam_tuser == s_ref_tuser;
  // a mismatch never consumes, so it cannot coincide with an end-of-frame join
  assign mismatch = state == RUN && both_v && s_cam_tuser != s_ref_tuser;
  assign eof      = join_ok && !s_cam_tuser && pix_cnt == PC_W'(FRAME_PIXELS - 1);
  // in ALIGN each stream drains independently until its head is SOF, then waits for the other
  assign s_cam_tready = !rst && (state == IDLE ? 1'b1 : state == ALIGN ? !cam_sof : join_ok);
  assign s_ref_tready = !rst && (state == IDLE ? 1'b1 : state == ALIGN ? !ref_sof : join_ok);
  always_comb
    state_n = state == IDLE  ? (enable ? ALIGN : IDLE) :
              state == ALIGN ? (!enable ? IDLE : cam_sof && ref_sof ? RUN : ALIGN) :
              state == RUN   ? (mismatch ? ALIGN : eof && !enable ? IDLE : RUN) : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state        <= IDLE;
      aligned      <= 1'b0;
      pix_cnt      <= '0;
      resync_count <= '0;
    end else begin
      state   <= state_n;
      aligned <= state_n == RUN;
      if (join_ok) pix_cnt <= s_cam_tuser ? PC_W'(1) : pix_cnt + 1'b1;
      if (mismatch && !(&resync_count)) resync_count <= resync_count + 1'b1;
    end
  axis_reg_slice #(.W(CAM_W + REF_W + 2)) u_out (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({s_cam_tdata, s_ref_tdata, s_cam_tuser, s_cam_tlast}),
    .s_valid (join_ok),
    .s_ready (slot_free),
    .m_data  ({m_tdata, m_tuser, m_tlast}),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );
endmodule
